// File: rtl/mult_controller_pkg.sv
// Shared definitions for the sequential 32x32 shift-and-add multiplier.
package mult_controller_pkg;

    localparam int DATA_W   = 32;
    localparam int ITER_CNT = 32;
    localparam int CNT_W    = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage : mult_controller_pkg

// File: rtl/adder32.sv
// Shared 32-bit ripple/carry adder used by the multiplier datapath.
module adder32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        c_in,
    output logic [31:0] sum,
    output logic        c_out
);

    assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {32'd0, c_in};

endmodule : adder32

// File: rtl/mult_controller.sv
// Sequential unsigned 32x32 multiplier: one shift-and-add iteration per
// clock through a single shared adder32, 32 iterations per product.
module mult_controller
    import mult_controller_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_W-1:0]     A,
    input  logic [DATA_W-1:0]     B,
    output logic                  busy,
    output logic                  done,
    output logic [2*DATA_W-1:0]   product
);

    state_t                 state_r;
    state_t                 next_state_s;
    logic [CNT_W-1:0]       count_r;
    logic [DATA_W-1:0]      hi_r;
    logic [DATA_W-1:0]      lo_r;
    logic [DATA_W-1:0]      mcand_r;
    logic                   busy_r;
    logic                   done_r;
    logic [DATA_W-1:0]      sum_s;
    logic                   c_out_s;
    logic [2*DATA_W-1:0]    next_prod_s;

    // Partial-product accumulation: hi + mcand, carry-in always zero.
    adder32 u_adder (
        .a     (hi_r),
        .b     (mcand_r),
        .c_in  (1'b0),
        .sum   (sum_s),
        .c_out (c_out_s)
    );

    // Next-state decode; the last RUN iteration is the one where count is 31.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_state_s = ST_RUN;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (count_r == CNT_W'(ITER_CNT - 1)) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // One shift-and-add step: add mcand into hi when the current multiplier
    // bit is set, then shift the 65-bit {carry, hi, lo} right by one.
    always_comb begin
        next_prod_s = {hi_r, lo_r};
        if (lo_r[0]) begin
            next_prod_s = {c_out_s, sum_s, lo_r[DATA_W-1:1]};
        end else begin
            next_prod_s = {1'b0, hi_r, lo_r[DATA_W-1:1]};
        end
    end

    // State register plus registered status flags derived from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s != ST_IDLE);
            done_r  <= (next_state_s == ST_DONE);
        end
    end

    // Datapath: operand capture on accept, one iteration per RUN cycle,
    // otherwise everything holds so the product stays readable.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {CNT_W{1'b0}};
            hi_r    <= {DATA_W{1'b0}};
            lo_r    <= {DATA_W{1'b0}};
            mcand_r <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        mcand_r <= A;
                        lo_r    <= B;
                        hi_r    <= {DATA_W{1'b0}};
                        count_r <= {CNT_W{1'b0}};
                    end else begin
                        mcand_r <= mcand_r;
                        lo_r    <= lo_r;
                        hi_r    <= hi_r;
                        count_r <= count_r;
                    end
                end
                ST_RUN: begin
                    {hi_r, lo_r} <= next_prod_s;
                    count_r      <= count_r + CNT_W'(1);
                end
                default: begin
                    mcand_r <= mcand_r;
                    lo_r    <= lo_r;
                    hi_r    <= hi_r;
                    count_r <= count_r;
                end
            endcase
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign product = {hi_r, lo_r};

endmodule : mult_controller

// File: tb/tb_mult_controller.sv
// Self-checking bench for mult_controller: directed cases plus randomized
// operations compared against a plain 64-bit multiply.
module tb_mult_controller;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [63:0] product;

    int total_checks;
    int failed_checks;

    mult_controller dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .A       (A),
        .B       (B),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_checks++;
        assert (obs === exp) else begin
            failed_checks++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] wa;
        logic [63:0] wb;
        wa = {32'd0, a};
        wb = {32'd0, b};
        return wa * wb;
    endfunction

    // Wait (bounded) for done; returns cycles counted from the accept edge.
    task automatic wait_done(output int cycles);
        cycles = 1;
        while (done !== 1'b1 && cycles < 40) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    // Launch one operation from IDLE (called away from the clock edge) and
    // check acceptance, latency, product and the single-cycle done pulse.
    // Operands are scrambled right after acceptance.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input string tag);
        int cyc;
        logic [63:0] exp;
        exp   = ref_mul(a, b);
        start = 1'b1;
        A     = a;
        B     = b;
        @(posedge clk); #1;
        start = 1'b0;
        A     = $urandom;
        B     = $urandom;
        check({tag, "_busy_accept"}, {63'd0, busy}, 64'd1);
        @(posedge clk); #1;
        wait_done(cyc);
        check({tag, "_latency"}, 64'(cyc), 64'd32);
        check({tag, "_product"}, product, exp);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, {62'd0, busy, done}, 64'd0);
        check({tag, "_product_hold"}, product, exp);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 4))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int cyc;
        int pulses;
        logic [31:0] ra;
        logic [31:0] rb;

        total_checks  = 0;
        failed_checks = 0;
        reset = 1'b1;
        start = 1'b0;
        A     = 32'd0;
        B     = 32'd0;

        // Reset state, including start held during reset.
        repeat (2) @(posedge clk);
        start = 1'b1;
        A     = 32'd9;
        B     = 32'd9;
        @(posedge clk); #1;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_product", product, 64'd0);

        // First start accepted on the first edge after reset deasserts.
        reset = 1'b0;
        run_op(32'd3, 32'd5, "a3b5");
        check("a3b5_const", product, 64'h0000_0000_0000_000F);

        // IDLE holds everything while start stays low.
        repeat (5) @(posedge clk);
        #1;
        check("idle_hold_product", product, 64'h0000_0000_0000_000F);
        check("idle_hold_busy", {63'd0, busy}, 64'd0);

        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, "ones");
        check("ones_const", product, 64'hFFFF_FFFE_0000_0001);
        run_op(32'd0, 32'h1234_5678, "zeroA");
        check("zeroA_const", product, 64'd0);
        run_op(32'h8000_0000, 32'd2, "msb");
        check("msb_const", product, 64'h0000_0001_0000_0000);

        // start held high through RUN and DONE: ignored, not queued.
        start = 1'b1;
        A     = 32'd7;
        B     = 32'd9;
        @(posedge clk); #1;
        A      = 32'd100;
        B      = 32'd100;
        pulses = 0;
        cyc    = 0;
        for (int i = 0; i < 32; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (done === 1'b1) pulses++;
        end
        check("hold_done_at_32", {63'd0, done}, 64'd1);
        check("hold_product", product, 64'd63);
        check("hold_pulses", 64'(pulses), 64'd1);
        @(posedge clk); #1;
        check("hold_idle_after_done", {62'd0, busy, done}, 64'd0);
        @(posedge clk); #1;
        start = 1'b0;
        check("hold_next_accepted", {63'd0, busy}, 64'd1);
        @(posedge clk); #1;
        wait_done(cyc);
        check("hold_next_latency", 64'(cyc), 64'd32);
        check("hold_next_product", product, 64'd10000);
        @(posedge clk); #1;

        // Reset mid-operation aborts without a done pulse.
        start = 1'b1;
        A     = 32'd6;
        B     = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_product", product, 64'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) pulses++;
        end
        check("abort_no_pulse", 64'(pulses), 64'd0);
        run_op(32'd6, 32'd7, "after_abort");
        check("after_abort_const", product, 64'd42);

        // Randomized back-to-back operations with corner operands mixed in.
        for (int n = 0; n < 1000; n++) begin
            ra = pick_operand();
            rb = pick_operand();
            run_op(ra, rb, "rand");
        end

        $display("%0d/%0d checks passed", total_checks - failed_checks, total_checks);
        $finish;
    end

endmodule : tb_mult_controller
